regfile_tagged: RTL and testbench

- Parametrised successor to the scalar 2-read/1-write register file, built for the out-of-order core.
- Holds architectural registers plus a per-register busy bit and producer tag (ROB index).
- NRD read ports return data/busy/tag with same-cycle commit bypass.
- Rename port marks a destination busy; commit port writes back and clears busy only on tag match; flush clears all busy state.

---
 rtl/regfile_tagged_pkg.sv | 19 +
 rtl/regfile_rd_port.sv | 47 ++++
 rtl/regfile_tagged.sv | 111 +++++++++++
 tb/tb_regfile_tagged.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_tagged_pkg.sv
// Shared constants and types for the tagged register file.
package regfile_tagged_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int NRD_DEF   = 2;
    localparam int TAG_W_DEF = 4;
    localparam int AW_DEF    = $clog2(NREG_DEF);

    localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

    // Enable levels for the one-bit enable inputs
    localparam logic EN_ON  = 1'b1;
    localparam logic EN_OFF = 1'b0;

    // Producer (ROB index) tag at the default width
    typedef logic [TAG_W_DEF-1:0] tag_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: applies reset/disable/x0 zeroing and the same-cycle commit
// bypass to the entry selected by the top.
module regfile_rd_port
    import regfile_tagged_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int AW    = AW_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [XLEN-1:0]  reg_data,
    input  logic             reg_busy,
    input  logic [TAG_W-1:0] reg_tag,
    input  logic             cmt_en,
    input  logic [AW-1:0]    cmt_addr,
    input  logic [TAG_W-1:0] cmt_tag,
    input  logic [XLEN-1:0]  cmt_data,
    output logic [XLEN-1:0]  rd_data,
    output logic             rd_busy,
    output logic [TAG_W-1:0] rd_tag
);

    logic bypass_hit;

    // A commit bypasses only when it is the producer the entry is waiting on
    assign bypass_hit = (cmt_en == EN_ON) && (cmt_addr == rd_addr) &&
                        reg_busy && (reg_tag == cmt_tag);

    // Output mux: zero when idle/reset/x0, else bypass or stored state
    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        rd_tag  = '0;
        if (!rst && (rd_en == EN_ON) && (rd_addr != '0)) begin
            if (bypass_hit) begin
                rd_data = cmt_data;
            end else begin
                rd_data = reg_data;
                rd_busy = reg_busy;
                rd_tag  = reg_busy ? reg_tag : '0;
            end
        end
    end

endmodule

// File: rtl/regfile_tagged.sv
// Register file with per-register busy bit and producer tag for the
// out-of-order core. Reads are combinational, so storage lives in flops.
module regfile_tagged
    import regfile_tagged_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int TAG_W = TAG_W_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    output logic [NRD*TAG_W-1:0] rd_tag,
    input  logic                 ren_en,
    input  logic [AW-1:0]        ren_addr,
    input  logic [TAG_W-1:0]     ren_tag,
    input  logic                 cmt_en,
    input  logic [AW-1:0]        cmt_addr,
    input  logic [TAG_W-1:0]     cmt_tag,
    input  logic [XLEN-1:0]      cmt_data,
    input  logic                 flush
);

    logic [XLEN-1:0]  data_q [NREG];
    logic             busy_q [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];

    genvar gi;

    // Per-register storage; entry 0 is constant zero and never busy
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign data_q[gi] = '0;
                assign busy_q[gi] = 1'b0;
                assign tag_q[gi]  = '0;
            end else begin : g_live
                logic [XLEN-1:0]  data_reg;
                logic             busy_reg;
                logic [TAG_W-1:0] tag_reg;
                logic             ren_hit;
                logic             cmt_hit;

                assign ren_hit = (ren_en == EN_ON) && (ren_addr == AW'(gi));
                assign cmt_hit = (cmt_en == EN_ON) && (cmt_addr == AW'(gi));

                // Commit always writes data; flush beats rename beats
                // a tag-matched commit for the busy/tag pair
                always_ff @(posedge clk) begin
                    if (rst) begin
                        data_reg <= '0;
                        busy_reg <= 1'b0;
                        tag_reg  <= '0;
                    end else begin
                        if (cmt_hit) begin
                            data_reg <= cmt_data;
                        end
                        if (flush) begin
                            busy_reg <= 1'b0;
                            tag_reg  <= '0;
                        end else if (ren_hit) begin
                            busy_reg <= 1'b1;
                            tag_reg  <= ren_tag;
                        end else if (cmt_hit && busy_reg && (tag_reg == cmt_tag)) begin
                            busy_reg <= 1'b0;
                            tag_reg  <= '0;
                        end
                    end
                end

                assign data_q[gi] = data_reg;
                assign busy_q[gi] = busy_reg;
                assign tag_q[gi]  = tag_reg;
            end
        end
    endgenerate

    // Read ports: select the addressed entry and hand it to the port mux
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            assign addr = rd_addr[gi*AW +: AW];

            regfile_rd_port #(
                .XLEN  (XLEN),
                .AW    (AW),
                .TAG_W (TAG_W)
            ) u_port (
                .rst      (rst),
                .rd_en    (rd_en[gi]),
                .rd_addr  (addr),
                .reg_data (data_q[addr]),
                .reg_busy (busy_q[addr]),
                .reg_tag  (tag_q[addr]),
                .cmt_en   (cmt_en),
                .cmt_addr (cmt_addr),
                .cmt_tag  (cmt_tag),
                .cmt_data (cmt_data),
                .rd_data  (rd_data[gi*XLEN +: XLEN]),
                .rd_busy  (rd_busy[gi]),
                .rd_tag   (rd_tag[gi*TAG_W +: TAG_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_tagged.sv
// Bench for regfile_tagged: directed scenarios with literal expectations,
// then random traffic checked every cycle against an array-based model.
module tb_regfile_tagged;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 2;
    localparam int TAG_W = 4;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NRD*TAG_W-1:0] rd_tag;
    logic                 ren_en;
    logic [AW-1:0]        ren_addr;
    logic [TAG_W-1:0]     ren_tag;
    logic                 cmt_en;
    logic [AW-1:0]        cmt_addr;
    logic [TAG_W-1:0]     cmt_tag;
    logic [XLEN-1:0]      cmt_data;
    logic                 flush;

    int checks   = 0;
    int failures = 0;

    regfile_tagged #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag),
        .cmt_en(cmt_en), .cmt_addr(cmt_addr), .cmt_tag(cmt_tag),
        .cmt_data(cmt_data), .flush(flush)
    );

    always #5 clk = ~clk;

    // Architectural model: value, pending flag and producer per register
    logic [XLEN-1:0]  m_val  [NREG];
    logic             m_pend [NREG];
    logic [TAG_W-1:0] m_prod [NREG];

    initial begin
        for (int i = 0; i < NREG; i++) begin
            m_val[i]  = '0;
            m_pend[i] = 1'b0;
            m_prod[i] = '0;
        end
    end

    // Model state update from the architectural rules
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_val[i]  <= '0;
                m_pend[i] <= 1'b0;
                m_prod[i] <= '0;
            end
        end else begin
            int ca, ra;
            bit renamed;
            ca = int'(cmt_addr);
            ra = int'(ren_addr);
            renamed = ren_en && !flush && ra != 0;
            if (cmt_en && ca != 0) m_val[ca] <= cmt_data;
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_pend[i] <= 1'b0;
            end else begin
                if (renamed) begin
                    m_pend[ra] <= 1'b1;
                    m_prod[ra] <= ren_tag;
                end
                if (cmt_en && ca != 0 && m_pend[ca] && m_prod[ca] == cmt_tag &&
                    !(renamed && ra == ca))
                    m_pend[ca] <= 1'b0;
            end
        end
    end

    // What a read port must return given model state and current inputs
    function automatic void model_read(input int k, output logic [XLEN-1:0] d,
                                       output logic b, output logic [TAG_W-1:0] t);
        int a;
        a = int'(rd_addr[k*AW +: AW]);
        d = '0; b = 1'b0; t = '0;
        if (rst || !rd_en[k] || a == 0) return;
        if (cmt_en && int'(cmt_addr) == a && m_pend[a] && m_prod[a] == cmt_tag) begin
            d = cmt_data;
            return;
        end
        d = m_val[a];
        b = m_pend[a];
        t = m_pend[a] ? m_prod[a] : '0;
    endfunction

    // Every-cycle comparison of all read ports against the model
    always @(negedge clk) begin
        for (int k = 0; k < NRD; k++) begin
            logic [XLEN-1:0]  ed;
            logic             eb;
            logic [TAG_W-1:0] et;
            model_read(k, ed, eb, et);
            checks++;
            if (rd_data[k*XLEN +: XLEN] !== ed || rd_busy[k] !== eb ||
                rd_tag[k*TAG_W +: TAG_W] !== et) begin
                failures++;
                $display("FAIL model_port%0d t=%0t got data=%h busy=%b tag=%h want data=%h busy=%b tag=%h",
                         k, $time, rd_data[k*XLEN +: XLEN], rd_busy[k],
                         rd_tag[k*TAG_W +: TAG_W], ed, eb, et);
            end
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic chk_port(input string name, input int k, input logic [XLEN-1:0] d,
                            input logic b, input logic [TAG_W-1:0] t);
        chk({name, "_data"}, rd_data[k*XLEN +: XLEN], d);
        chk({name, "_busy"}, XLEN'(rd_busy[k]), XLEN'(b));
        chk({name, "_tag"},  XLEN'(rd_tag[k*TAG_W +: TAG_W]), XLEN'(t));
    endtask

    task automatic clear_in();
        rst = 1'b0; rd_en = '0; rd_addr = '0;
        ren_en = 1'b0; ren_addr = '0; ren_tag = '0;
        cmt_en = 1'b0; cmt_addr = '0; cmt_tag = '0; cmt_data = '0;
        flush = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic rd(input int k, input int a);
        rd_en[k] = 1'b1;
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic ren(input int a, input int t);
        ren_en = 1'b1; ren_addr = AW'(a); ren_tag = TAG_W'(t);
    endtask

    task automatic cmt(input int a, input int t, input logic [XLEN-1:0] d);
        cmt_en = 1'b1; cmt_addr = AW'(a); cmt_tag = TAG_W'(t); cmt_data = d;
    endtask

    initial begin
        clear_in();
        // Reset active: reads forced to zero
        rst = 1'b1; rd(0, 5); rd(1, 31);
        #4 chk_port("in_reset_p0", 0, 32'h0, 1'b0, 4'h0);

        next(); rd(0, 5); rd(1, 31);
        #3 chk_port("after_reset_x5", 0, 32'h0, 1'b0, 4'h0);
        chk_port("after_reset_x31", 1, 32'h0, 1'b0, 4'h0);

        // Rename then commit with bypass
        next(); ren(3, 7);
        next(); rd(0, 3);
        #3 chk_port("renamed_x3", 0, 32'h0, 1'b1, 4'h7);
        next(); rd(0, 3); cmt(3, 7, 32'hDEADBEEF);
        #3 chk_port("bypass_x3", 0, 32'hDEADBEEF, 1'b0, 4'h0);
        next(); rd(1, 3);
        #3 chk_port("committed_x3", 1, 32'hDEADBEEF, 1'b0, 4'h0);

        // Stale commit: data stored, producer unchanged, no bypass
        next(); ren(4, 2);
        next(); ren(4, 9);
        next(); cmt(4, 2, 32'h11); rd(0, 4);
        #3 chk_port("stale_nobypass_x4", 0, 32'h0, 1'b1, 4'h9);
        next(); rd(0, 4);
        #3 chk_port("stale_after_x4", 0, 32'h11, 1'b1, 4'h9);

        // Same-cycle rename and commit on one register
        next(); ren(6, 1);
        next(); ren(6, 5); cmt(6, 1, 32'h22);
        next(); rd(1, 6);
        #3 chk_port("ren_cmt_x6", 1, 32'h22, 1'b1, 4'h5);

        // Flush clears pending state, ignores rename, keeps data
        next(); ren(7, 3); cmt(8, 0, 32'h88);
        next(); ren(8, 4);
        next(); flush = 1'b1; ren(9, 6);
        next(); rd(0, 7); rd(1, 8);
        #3 chk_port("flush_x7", 0, 32'h0, 1'b0, 4'h0);
        chk_port("flush_x8", 1, 32'h88, 1'b0, 4'h0);
        next(); rd(0, 9); rd(1, 3);
        #3 chk_port("flush_x9", 0, 32'h0, 1'b0, 4'h0);
        chk_port("flush_keep_x3", 1, 32'hDEADBEEF, 1'b0, 4'h0);

        // x0 guard and disabled port
        next(); ren(0, 1); cmt(0, 1, 32'h55);
        next(); rd(0, 0); rd(1, 0);
        #3 chk_port("x0_p0", 0, 32'h0, 1'b0, 4'h0);
        chk_port("x0_p1", 1, 32'h0, 1'b0, 4'h0);
        next(); rd_addr[AW-1:0] = AW'(4);
        #3 chk_port("disabled_x4", 0, 32'h0, 1'b0, 4'h0);

        // Reset wins over same-cycle rename
        next(); ren(2, 5); rst = 1'b1;
        next(); rd(0, 2); rd(1, 6);
        #3 chk_port("rst_prio_x2", 0, 32'h0, 1'b0, 4'h0);
        chk_port("rst_clears_x6", 1, 32'h0, 1'b0, 4'h0);

        // Random traffic, narrowed address/tag ranges to force collisions
        for (int n = 0; n < 3000; n++) begin
            next();
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < NRD; k++)
                if ($urandom_range(0, 5) != 0) rd(k, $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) ren($urandom_range(0, 7), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                cmt($urandom_range(0, 7), $urandom_range(0, 3), $urandom);
        end

        next();
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
